wb_spi_controller: RTL and testbench
====================================

// Module: wb_spi_controller
// PURPOSE
//  Wishbone peripheral that acts as an SPI controller: the initiating end of the SPI link
//  whose peripheral end bridges SPI into our Wishbone bus. Software writes a byte and the
//  block drives csn/sck/sdo in SPI mode 0, MSB first, capturing sdi into an RX register.
//  Sits behind the Wishbone interconnect as one peripheral slot; SPI pins go to top-level IO.
// PARAMETERS
//  pClkDiv  2  clk cycles per SCK half-period; legal range 1..255
// PORTS
//  clk        in   1  single system clock; all logic on posedge clk
//  rst_n      in   1  asynchronous active-low reset; deassertion synchronised externally
//  wb_stb     in   1  Wishbone strobe, with cyc already qualified by interconnect
//  wb_we      in   1  1 = write, 0 = read
//  wb_adr     in   2  register index
//  wb_dat_i   in   8  write data
//  wb_dat_o   out  8  read data; valid only while wb_ack=1, else 0
//  wb_ack     out  1  one-cycle acknowledge
//  spi_sck    out  1  SPI clock, idles low (CPOL=0)
//  spi_csn    out  1  chip select, active low
//  spi_sdo    out  1  controller-out data
//  spi_sdi    in   1  controller-in data
// BEHAVIOUR
//  Reset (rst_n=0, async): wb_ack=0, wb_dat_o=0, spi_sck=0, spi_csn=1, spi_sdo=0.
//   Also: state IDLE, rx=0, busy=0, rx_valid=0, overrun=0, cs_hold=0.
//   Reset mid-transfer aborts immediately: csn rises in the same cycle, no partial rx kept.
//  Registers:
//   0 DATA  W: start transfer of wb_dat_i. R: rx byte; clears rx_valid.
//   1 STAT  R: {5'b0, overrun, rx_valid, busy}. Read clears overrun. Writes ignored.
//   2 CTRL  R/W: bit0 cs_hold. 1 keeps csn low between bytes for multi-byte frames.
//           Writing 0 while idle with csn low raises csn next cycle.
//   3       reads 0; writes ignored.
//  Wishbone handshake:
//   - wb_ack=1 exactly one cycle after any cycle with wb_stb=1 and wb_ack=0.
//   - Back-to-back strobe gets ack every second cycle.
//   - Register side effects are applied at the ack cycle.
//  Write DATA while busy=1: acked, data discarded, overrun set (sticky), transfer unaffected.
//  FSM: IDLE -> SETUP -> (HIGH -> LOW) x8 -> DONE -> IDLE. Each state lasts pClkDiv cycles.
//   IDLE:  on accepted DATA write, load shifter, busy=1, csn=0, sdo=shifter[7] -> SETUP.
//   SETUP: csn low, sck low; satisfies setup time for bit 7.
//   HIGH:  sck=1; sdi sampled into shifter LSB on the clk edge entering HIGH.
//   LOW:   sck=0; on entry, shift left and drive next sdo. After 8th LOW -> DONE.
//   DONE:  sck=0, sdo held. At exit: rx=shifter, rx_valid=1, busy=0.
//          If cs_hold=0, csn=1 at exit; otherwise csn stays low.
//   busy is high for exactly 18*pClkDiv cycles from the ack cycle.
//  Simultaneous events:
//   - DATA read in the cycle rx is updated returns the new byte and leaves rx_valid=0.
//   - STAT read concurrent with overrun set leaves overrun=1.
//  Divider counter is 8 bit; reloads to pClkDiv-1 on every state change; no wrap in IDLE.
// STRUCTURE
//  Package wb_spi_pkg:
//   - localparams REG_DATA=0, REG_STAT=1, REG_CTRL=2
//   - STAT bit indices
//   - typedef enum logic[2:0] {IDLE,SETUP,HIGH,LOW,DONE} spi_state_t
//  Sub-module spi_ctrl_tick: pClkDiv half-period counter with restart input and tick output.
//  Everything else (register file, FSM, shifter, 3-bit bit counter) stays in this module.
// TESTING (pClkDiv=2 unless noted)
//  1. Reset: hold rst_n=0 -> csn=1, sck=0, sdo=0, ack=0; STAT reads 0x00.
//  2. Write DATA=0xA5, sdi looped from sdo:
//     -> 8 sck pulses of 4-cycle period; sdo bits 1,0,1,0,0,1,0,1 on sck rise;
//        csn high 36 cycles after ack; STAT=0x02; DATA reads 0xA5; STAT then 0x00.
//  3. sdi tied 1, write 0x00 -> rx 0xFF; sdi tied 0, write 0xFF -> rx 0x00.
//  4. Write DATA=0x11, then DATA=0x22 while busy
//     -> only 0x11 shifted; STAT=0x06; second STAT read=0x02.
//  5. CTRL=1, write 0x3C then 0xC3 after busy drops -> csn low across both bytes;
//     CTRL=0 -> csn high next cycle.
//  6. Drop rst_n at 3rd sck rise -> csn=1, sck=0 same cycle; after release STAT=0x00.
//     Repeat test 2 with pClkDiv=1 -> busy 18 cycles.

Source files
------------

// File: rtl/wb_spi_pkg.sv
// Shared constants and types for the Wishbone SPI controller.
package wb_spi_pkg;

    // Register map
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    // STAT bit positions
    localparam int STAT_BUSY     = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_OVERRUN  = 2;

    // CTRL bit positions
    localparam int CTRL_CS_HOLD  = 0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DONE
    } spi_state_t;

    // One bus access as seen by the register file
    typedef struct packed {
        logic       we;
        logic [1:0] adr;
        logic [7:0] dat;
    } wb_req_t;

endpackage

// File: rtl/spi_ctrl_tick.sv
// SCK half-period divider: tick marks the last clk cycle of each FSM state.
// Held at reload while restart is high so every state lasts exactly pClkDiv cycles.
module spi_ctrl_tick #(
    parameter int unsigned pClkDiv = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(pClkDiv - 1);

    logic [7:0] cnt_q;

    assign tick = ~restart && (cnt_q == 8'd0);

    // Down-counter; reloads on restart and on every tick (i.e. every state change)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt_q <= RELOAD;
        else if (restart || tick)  cnt_q <= RELOAD;
        else                       cnt_q <= cnt_q - 8'd1;
    end

endmodule

// File: rtl/wb_spi_controller.sv
// Wishbone-attached SPI controller, mode 0, MSB first, one byte per DATA write.
// Bus accesses take effect on the same edge that raises wb_ack.
module wb_spi_controller
    import wb_spi_pkg::*;
#(
    parameter int unsigned pClkDiv = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wb_stb,
    input  logic       wb_we,
    input  logic [1:0] wb_adr,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack,
    output logic       spi_sck,
    output logic       spi_csn,
    output logic       spi_sdo,
    input  logic       spi_sdi
);

    wb_req_t    req;
    logic       access;
    logic       data_wr, data_rd, stat_rd, ctrl_wr;
    logic       busy, start, tick, idle;
    logic       done_exit, enter_high, enter_low;
    spi_state_t state_q, state_d;
    logic [2:0] bit_cnt_q;
    logic [7:0] shifter_q, rx_q, rdata;
    logic       rx_valid_q, overrun_q, cs_hold_q;

    assign req     = '{we: wb_we, adr: wb_adr, dat: wb_dat_i};
    assign access  = wb_stb & ~wb_ack;
    assign data_wr = access &  req.we & (req.adr == REG_DATA);
    assign data_rd = access & ~req.we & (req.adr == REG_DATA);
    assign stat_rd = access & ~req.we & (req.adr == REG_STAT);
    assign ctrl_wr = access &  req.we & (req.adr == REG_CTRL);

    assign idle  = (state_q == IDLE);
    assign busy  = ~idle;
    assign start = data_wr & idle;

    spi_ctrl_tick #(.pClkDiv(pClkDiv)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (idle),
        .tick    (tick)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus one-cycle strobes marking state entries/exit
    always_comb begin
        state_d    = state_q;
        enter_high = 1'b0;
        enter_low  = 1'b0;
        done_exit  = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = SETUP;
            SETUP: if (tick) begin state_d = HIGH; enter_high = 1'b1; end
            HIGH:  if (tick) begin state_d = LOW;  enter_low  = 1'b1; end
            LOW:   if (tick) begin
                       if (bit_cnt_q == 3'd7) state_d = DONE;
                       else begin state_d = HIGH; enter_high = 1'b1; end
                   end
            DONE:  if (tick) begin state_d = IDLE; done_exit = 1'b1; end
            default: state_d = IDLE;
        endcase
    end

    // Bit counter: counts completed LOW phases, wraps 7->0 at the end of a byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              bit_cnt_q <= 3'd0;
        else if (start)                          bit_cnt_q <= 3'd0;
        else if (state_q == LOW && tick)         bit_cnt_q <= bit_cnt_q + 3'd1;
    end

    // Shifter: loads TX byte, then takes sdi into the LSB on each rising SCK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          shifter_q <= 8'h00;
        else if (start)      shifter_q <= req.dat;
        else if (enter_high) shifter_q <= {shifter_q[6:0], spi_sdi};
    end

    // SPI pins; sdo changes only on falling SCK so it is stable around each rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_sck <= 1'b0;
            spi_sdo <= 1'b0;
            spi_csn <= 1'b1;
        end else begin
            spi_sck <= (state_d == HIGH);
            if (start)
                spi_sdo <= req.dat[7];
            else if (enter_low && bit_cnt_q != 3'd7)
                spi_sdo <= shifter_q[7];
            // csn drops on start; rises at byte end or once cs_hold is cleared while idle
            if (start)
                spi_csn <= 1'b0;
            else if ((done_exit || idle) && !cs_hold_q)
                spi_csn <= 1'b1;
        end
    end

    // RX byte and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q       <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (done_exit) rx_q <= shifter_q;
            // a DATA read in the update cycle consumes the new byte
            if (data_rd)        rx_valid_q <= 1'b0;
            else if (done_exit) rx_valid_q <= 1'b1;
            // a new overrun beats a concurrent STAT read clear
            if (data_wr && busy) overrun_q <= 1'b1;
            else if (stat_rd)    overrun_q <= 1'b0;
        end
    end

    // CTRL register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cs_hold_q <= 1'b0;
        else if (ctrl_wr) cs_hold_q <= req.dat[CTRL_CS_HOLD];
    end

    // Read mux; DATA forwards the byte being captured this cycle
    always_comb begin
        rdata = 8'h00;
        case (req.adr)
            REG_DATA: rdata = done_exit ? shifter_q : rx_q;
            REG_STAT: begin
                rdata[STAT_BUSY]     = busy;
                rdata[STAT_RX_VALID] = rx_valid_q;
                rdata[STAT_OVERRUN]  = overrun_q;
            end
            REG_CTRL: rdata[CTRL_CS_HOLD] = cs_hold_q;
            default:  rdata = 8'h00;
        endcase
    end

    // Ack one cycle after an unacked strobe; read data only alongside ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_dat_o <= 8'h00;
        end else begin
            wb_ack   <= access;
            wb_dat_o <= (access && !req.we) ? rdata : 8'h00;
        end
    end

endmodule

// File: tb/tb_wb_spi_controller.sv
// Scoreboard bench: stimulus pushes expected bus read data and SDO bits,
// a monitor pops and compares them as the DUTs present acks and SCK rises.
module tb_wb_spi_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wb_we = 1'b0;
    logic [1:0] wb_adr = 2'd0;
    logic [7:0] wb_dat_i = 8'h00;
    logic       stb0 = 1'b0, stb1 = 1'b0;
    logic [7:0] dat0, dat1;
    logic       ack0, ack1, sck0, sck1, csn0, csn1, sdo0, sdo1, sdi0, sdi1;
    logic       sdi_loop = 1'b1, sdi_const = 1'b0;
    logic       sel = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] wbq[$];
    logic       sdoq[$];

    always #5 clk = ~clk;

    assign sdi0 = sdi_loop ? sdo0 : sdi_const;
    assign sdi1 = sdo1;

    wb_spi_controller #(.pClkDiv(2)) dut (
        .clk(clk), .rst_n(rst_n), .wb_stb(stb0), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_i(wb_dat_i), .wb_dat_o(dat0), .wb_ack(ack0), .spi_sck(sck0),
        .spi_csn(csn0), .spi_sdo(sdo0), .spi_sdi(sdi0)
    );

    wb_spi_controller #(.pClkDiv(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wb_stb(stb1), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_i(wb_dat_i), .wb_dat_o(dat1), .wb_ack(ack1), .spi_sck(sck1),
        .spi_csn(csn1), .spi_sdo(sdo1), .spi_sdi(sdi1)
    );

    logic sck_m, sdo_m, csn_m;
    int   div_m;
    assign sck_m = sel ? sck1 : sck0;
    assign sdo_m = sel ? sdo1 : sdo0;
    assign csn_m = sel ? csn1 : csn0;
    assign div_m = sel ? 1 : 2;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: bus read data on every ack, SDO bit and SCK period on every SCK rise
    logic sck_prev = 1'b0;
    int   bi = 0;
    int   gap = 0;
    initial begin : monitor
        logic [7:0] e;
        logic       eb;
        forever begin
            @(negedge clk);
            if (ack0 || ack1) begin
                chk("wb_pending_req", int'(wbq.size() > 0), 1);
                if (wbq.size() > 0) begin
                    e = wbq.pop_front();
                    chk("wb_dat_o", ack0 ? dat0 : dat1, e);
                end
            end
            gap++;
            if (sck_m && !sck_prev) begin
                chk("sdo_pending_bit", int'(sdoq.size() > 0), 1);
                if (sdoq.size() > 0) begin
                    eb = sdoq.pop_front();
                    chk("sdo_bit", sdo_m, eb);
                end
                if (bi != 0) chk("sck_period", gap, 2 * div_m);
                bi  = (bi + 1) % 8;
                gap = 0;
            end
            if (csn_m) bi = 0;
            sck_prev = sck_m;
        end
    end

    task automatic bus(input bit we, input logic [1:0] adr, input logic [7:0] dat,
                       input logic [7:0] exp);
        @(posedge clk); #1;
        wbq.push_back(we ? 8'h00 : exp);
        wb_we = we; wb_adr = adr; wb_dat_i = dat;
        if (sel) stb1 = 1'b1; else stb0 = 1'b1;
        @(posedge clk); #1;
        stb0 = 1'b0; stb1 = 1'b0;
    endtask

    task automatic wr(input logic [1:0] adr, input logic [7:0] dat);
        bus(1'b1, adr, dat, 8'h00);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [7:0] exp);
        bus(1'b0, adr, 8'h00, exp);
    endtask

    // DATA write expected to start a transfer: queue its bits MSB first
    task automatic send(input logic [7:0] dat);
        for (int i = 7; i >= 0; i--) sdoq.push_back(dat[i]);
        wr(2'd0, dat);
    endtask

    // Negedges with csn low until it rises (bounded)
    task automatic wait_csn_high(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (csn_m) break;
            n++;
        end
    endtask

    initial begin : stim
        int n;
        int rises;
        int highs;
        logic p;

        // 1. reset
        #3 rst_n = 1'b0;
        #1;
        chk("rst_csn", csn0, 1);
        chk("rst_sck", sck0, 0);
        chk("rst_sdo", sdo0, 0);
        chk("rst_ack", ack0, 0);
        chk("rst_dat_o", dat0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(2'd1, 8'h00);
        rd(2'd2, 8'h00);
        wr(2'd3, 8'hFF);
        rd(2'd3, 8'h00);
        wr(2'd1, 8'hFF);
        rd(2'd1, 8'h00);

        // 2. loopback 0xA5
        send(8'hA5);
        wait_csn_high(n);
        chk("csn_low_cycles_div2", n, 36);
        rd(2'd1, 8'h02);
        rd(2'd0, 8'hA5);
        rd(2'd1, 8'h00);

        // 3. constant sdi
        sdi_loop = 1'b0; sdi_const = 1'b1;
        send(8'h00);
        wait_csn_high(n);
        chk("csn_low_sdi1", n, 36);
        rd(2'd0, 8'hFF);
        sdi_const = 1'b0;
        send(8'hFF);
        wait_csn_high(n);
        chk("csn_low_sdi0", n, 36);
        rd(2'd0, 8'h00);
        sdi_loop = 1'b1;

        // 4. overrun
        send(8'h11);
        wr(2'd0, 8'h22);
        wait_csn_high(n);
        chk("csn_low_after_overrun_wr", n, 34);
        rd(2'd1, 8'h06);
        rd(2'd1, 8'h02);
        rd(2'd0, 8'h11);
        rd(2'd1, 8'h00);

        // 5. cs_hold across two bytes
        wr(2'd2, 8'h01);
        rd(2'd2, 8'h01);
        send(8'h3C);
        highs = 0;
        repeat (40) begin @(negedge clk); if (csn0) highs++; end
        chk("cs_hold_byte1_csn_high", highs, 0);
        send(8'hC3);
        highs = 0;
        repeat (40) begin @(negedge clk); if (csn0) highs++; end
        chk("cs_hold_byte2_csn_high", highs, 0);
        rd(2'd1, 8'h02);
        rd(2'd0, 8'hC3);
        wr(2'd2, 8'h00);
        @(negedge clk);
        chk("cs_release_ack_cycle", csn0, 0);
        @(negedge clk);
        chk("cs_release_next_cycle", csn0, 1);

        // 6. reset at third SCK rise
        send(8'hA5);
        rises = 0;
        p = 1'b0;
        for (int i = 0; i < 200 && rises < 3; i++) begin
            @(negedge clk);
            if (sck0 && !p) rises++;
            p = sck0;
        end
        chk("third_rise_reached", rises, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_csn", csn0, 1);
        chk("abort_sck", sck0, 0);
        chk("abort_sdo", sdo0, 0);
        sdoq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(2'd1, 8'h00);
        rd(2'd0, 8'h00);

        // 6b. pClkDiv = 1
        sel = 1'b1;
        send(8'hA5);
        wait_csn_high(n);
        chk("csn_low_cycles_div1", n, 18);
        rd(2'd1, 8'h02);
        rd(2'd0, 8'hA5);
        rd(2'd1, 8'h00);

        repeat (3) @(negedge clk);
        chk("wb_queue_drained", wbq.size(), 0);
        chk("sdo_queue_drained", sdoq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
